// File: rtl/mm_result_buffer.sv
// Output/accumulate buffer responder for the mm engine: fixed-latency pipelined
// reads, always-accepted result writes, and a CLEAR sequencer that zeroes a range.
module mm_result_buffer #(
    parameter int DATA_W       = 512,
    parameter int ADDR_W       = 11,
    parameter int READ_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_addr_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_data_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clear_start,
    input  logic [ADDR_W-1:0] clear_base,
    input  logic [ADDR_W:0]   clear_len,
    output logic              clear_busy,
    output logic              clear_done
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     remaining_q, remaining_d;
    logic                clear_busy_q, clear_busy_d;
    logic                clear_done_q, clear_done_d;

    logic                mem_we_s;
    logic [ADDR_W-1:0]   mem_waddr_s;
    logic [DATA_W-1:0]   mem_wdata_s;
    logic [DATA_W-1:0]   rd_word_s;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [DATA_W-1:0]       pipe_data_q [READ_LATENCY];
    logic [DATA_W-1:0]       pipe_data_d [READ_LATENCY];

    // CLEAR sequencer next-state logic; an engine write stalls the sweep.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        remaining_d  = remaining_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_start) begin
                    ptr_d       = clear_base;
                    remaining_d = clear_len;
                    if (clear_len != (ADDR_W + 1)'(0)) begin
                        state_d = ST_CLEAR;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (!wr_valid) begin
                    ptr_d       = ptr_q + ADDR_W'(1);
                    remaining_d = remaining_q - (ADDR_W + 1)'(1);
                    if (remaining_q == (ADDR_W + 1)'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CLEAR;
                    end
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        clear_busy_d = (state_d == ST_CLEAR);
        clear_done_d = (state_d == ST_DONE);
    end

    // CLEAR sequencer state and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            remaining_q  <= '0;
            clear_busy_q <= 1'b0;
            clear_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            remaining_q  <= remaining_d;
            clear_busy_q <= clear_busy_d;
            clear_done_q <= clear_done_d;
        end
    end

    // Single storage write port: engine write has priority over the clear sweep.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = wr_addr;
        mem_wdata_s = wr_data;
        if (wr_valid) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = wr_addr;
            mem_wdata_s = wr_data;
        end else if (state_q == ST_CLEAR) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = ptr_q;
            mem_wdata_s = '0;
        end else begin
            mem_we_s    = 1'b0;
        end
    end

    // Storage array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Write-first bypass, then a valid/data shift pipeline. Data is captured at
    // request time so later writes cannot disturb words already in flight.
    always_comb begin
        if (mem_we_s && (mem_waddr_s == rd_addr)) begin
            rd_word_s = mem_wdata_s;
        end else begin
            rd_word_s = mem[rd_addr];
        end
        pipe_vld_d[0]  = rd_addr_valid;
        pipe_data_d[0] = rd_addr_valid ? rd_word_s : '0;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_data_d[i] = pipe_data_q[i-1];
        end
    end

    // Read pipeline registers; reset drops anything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_data_q[i] <= '0;
            end
        end else begin
            pipe_vld_q <= pipe_vld_d;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_data_q[i] <= pipe_data_d[i];
            end
        end
    end

    assign rd_data_valid = pipe_vld_q[READ_LATENCY-1];
    assign rd_data       = pipe_data_q[READ_LATENCY-1];
    assign clear_busy    = clear_busy_q;
    assign clear_done    = clear_done_q;

endmodule
